lc3_fetch_queue: RTL

- Fetch stage directly upstream of the decode stage.
- Generates sequential instruction addresses from a PC register and issues them to instruction memory over a req/ready request channel with an in-order rvalid response.
- Buffers returned instructions in a small queue and presents them to decode as npc_out / instr_dout / enable_decode.
- Handles branch redirects by flushing the queue and discarding in-flight responses.

---
 rtl/lc3_fetch_queue_if.sv | 12 +
 rtl/lc3_fetch_queue.sv | 118 +++++++++++
 2 files changed

// File: rtl/lc3_fetch_queue_if.sv
// Instruction-memory request/response channel between the fetch queue and imem.
// The fetch side drives req/addr and receives ready plus in-order rvalid/rdata.
interface lc3_fetch_queue_if;
   logic        req;
   logic [15:0] addr;
   logic        ready;
   logic        rvalid;
   logic [15:0] rdata;

   modport master (output req, addr, input ready, rvalid, rdata);
   modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/lc3_fetch_queue.sv
// LC-3 fetch stage: PC-driven imem requests, small instruction queue, redirect flush.
// Optional LC3_FETCH_STATS_EN adds fetch_count / flush_count outputs.
module lc3_fetch_queue #(
   parameter logic [15:0] RESET_PC    = 16'h3000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   lc3_fetch_queue_if.master        imem,
   input  logic                     br_taken,
   input  logic [15:0]              taddr,
   input  logic                     stall,
   output logic                     enable_decode,
   output logic [15:0]              instr_dout,
   output logic [15:0]              npc_out
`ifdef LC3_FETCH_STATS_EN
   ,
   output logic [15:0]              fetch_count,
   output logic [7:0]               flush_count
`endif
);
   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = CW + 2;

   logic [15:0]   pc;
   logic [CW-1:0] occ;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] af_head;
   logic [AW-1:0] af_tail;
   logic [15:0]   q_instr [QUEUE_DEPTH];
   logic [15:0]   q_npc   [QUEUE_DEPTH];
   logic [15:0]   af_addr [QUEUE_DEPTH];
   logic [SW-1:0] in_use;
   logic          accept;
   logic          resp_drop;
   logic          resp_push;
   logic          pop;

   // Every buffered, in-flight or to-be-discarded slot counts against the depth,
   // which is what guarantees a push never finds the queue full.
   assign in_use        = SW'(occ) + SW'(outstanding) + SW'(discard);
   assign imem.req      = reset && !br_taken && (in_use < SW'(QUEUE_DEPTH));
   assign imem.addr     = pc;
   assign accept        = imem.req && imem.ready;
   assign resp_drop     = imem.rvalid && (discard != '0);
   assign resp_push     = imem.rvalid && (discard == '0) && (outstanding != '0) && !br_taken;
   assign enable_decode = (occ != '0) && !stall && !br_taken;
   assign pop           = enable_decode;
   assign instr_dout    = (occ != '0) ? q_instr[head] : 16'h0000;
   assign npc_out       = (occ != '0) ? q_npc[head]   : 16'h0000;

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc          <= RESET_PC;
         occ         <= '0;
         outstanding <= '0;
         discard     <= '0;
         head        <= '0;
         tail        <= '0;
         af_head     <= '0;
         af_tail     <= '0;
      end else if (br_taken) begin
         // A response landing in this cycle belongs to the old in-flight set.
         pc          <= taddr;
         occ         <= '0;
         head        <= '0;
         tail        <= '0;
         af_head     <= '0;
         af_tail     <= '0;
         outstanding <= '0;
         discard     <= discard + outstanding
                        - CW'(imem.rvalid && ((discard != '0) || (outstanding != '0)));
      end else begin
         if (accept) begin
            pc      <= pc + 16'd1;
            af_tail <= af_tail + AW'(1);
         end
         if (resp_push) begin
            tail    <= tail + AW'(1);
            af_head <= af_head + AW'(1);
         end
         if (resp_drop)
            discard <= discard - CW'(1);
         if (pop)
            head <= head + AW'(1);
         outstanding <= outstanding + CW'(accept) - CW'(resp_push);
         occ         <= occ + CW'(resp_push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (accept)
         af_addr[af_tail] <= pc;
      if (resp_push) begin
         q_instr[tail] <= imem.rdata;
         q_npc[tail]   <= af_addr[af_head] + 16'd1;
      end
   end

`ifdef LC3_FETCH_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (pop)
            fetch_count <= fetch_count + 16'd1;
         if (br_taken && (flush_count != 8'hFF))
            flush_count <= flush_count + 8'd1;
      end
   end
`endif

endmodule
